// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding unit.
//   FWD_*        : EX-stage operand source selects
//   slot_entry_t : one in-flight destination record in the scoreboard pipe
package hazard_pkg;

  localparam logic [1:0] FWD_RF    = 2'b00;
  localparam logic [1:0] FWD_EXMEM = 2'b01;
  localparam logic [1:0] FWD_MEMWB = 2'b10;

  // Entries carry a fixed-width dest field so the struct can live in a
  // package; users zero-extend their REG_ADDR_WIDTH address into it and
  // compare only the low REG_ADDR_WIDTH bits (REG_ADDR_WIDTH <= 8).
  localparam int unsigned SLOT_DEST_W = 8;

  typedef struct packed {
    logic                   valid;
    logic [SLOT_DEST_W-1:0] dest;
    logic                   is_load;
  } slot_entry_t;

  localparam slot_entry_t SLOT_BUBBLE = '0;

endpackage

// File: rtl/dest_scoreboard_pipe.sv
// NUM_SLOTS-deep shift register of in-flight destination entries.
//   i_clk, i_rst : clock, synchronous active-high reset (all slots invalid)
//   i_insert     : 1 = load i_entry into slot1, 0 = load a bubble
//   i_entry      : entry for the instruction leaving ID
//   o_slots      : per-slot contents, index 0 = slot1 (EX)
module dest_scoreboard_pipe
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_SLOTS = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_insert,
  input  slot_entry_t                   i_entry,
  output slot_entry_t [NUM_SLOTS-1:0]   o_slots
);

  slot_entry_t [NUM_SLOTS-1:0] r_slots;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_slots <= '0;
    end else begin
      r_slots[0] <= i_insert ? i_entry : SLOT_BUBBLE;
      for (int unsigned k = 1; k < NUM_SLOTS; k++) begin
        r_slots[k] <= r_slots[k-1];
      end
    end
  end

  assign o_slots = r_slots;

endmodule

// File: rtl/hazard_forward_unit.sv
// ID-side hazard detector with registered EX forwarding selects.
//   i_clk, i_rst        : pipeline clock, synchronous active-high reset
//   i_id_valid          : ID holds a real instruction
//   i_id_src_a/_used    : first source register and its use flag
//   i_id_src_b/_used    : second source register and its use flag
//   i_id_dest/_we       : destination register and write enable
//   i_id_is_load        : result comes from data memory
//   i_flush             : kill the ID instruction (jump taken)
//   o_stall             : hold PC and IF_ID, bubble into EX (combinational)
//   o_fwd_sel_a/_b      : EX operand source, 00 RF / 01 EX_MEM / 10 MEM_WB
//   o_stall_count       : saturating count of stalled cycles
module hazard_forward_unit
  import hazard_pkg::*;
#(
  parameter int unsigned REG_ADDR_WIDTH  = 4,
  parameter int unsigned NUM_SLOTS       = 3,
  parameter int unsigned FORWARD_EN      = 1,
  parameter int unsigned R0_ZERO         = 0,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  input  logic                       i_id_valid,
  input  logic [REG_ADDR_WIDTH-1:0]  i_id_src_a,
  input  logic                       i_id_src_a_used,
  input  logic [REG_ADDR_WIDTH-1:0]  i_id_src_b,
  input  logic                       i_id_src_b_used,
  input  logic [REG_ADDR_WIDTH-1:0]  i_id_dest,
  input  logic                       i_id_dest_we,
  input  logic                       i_id_is_load,
  input  logic                       i_flush,
  output logic                       o_stall,
  output logic [1:0]                 o_fwd_sel_a,
  output logic [1:0]                 o_fwd_sel_b,
  output logic [STALL_CNT_WIDTH-1:0] o_stall_count
);

  slot_entry_t [NUM_SLOTS-1:0] w_slots;
  slot_entry_t                 w_entry;
  logic                        w_insert;
  logic                        w_hit_a1, w_hit_a2, w_hit_b1, w_hit_b2;
  logic                        w_hazard;
  logic                        w_stall;
  logic [1:0]                  w_fwd_a_nxt, w_fwd_b_nxt;
  logic                        w_unused_slot_bits;

  logic [1:0]                  r_fwd_a, r_fwd_b;
  logic [STALL_CNT_WIDTH-1:0]  r_stall_cnt;

  function automatic logic f_match(input slot_entry_t              e,
                                   input logic                     used,
                                   input logic [REG_ADDR_WIDTH-1:0] src);
    logic r0_blocked;
    r0_blocked = (R0_ZERO != 0) && (src == '0);
    return e.valid && used && (e.dest[REG_ADDR_WIDTH-1:0] == src) && !r0_blocked;
  endfunction

  // Youngest producer wins; slot3 never needs a path because the RF is
  // write-through.
  function automatic logic [1:0] f_sel(input logic hit1, input logic hit2);
    if (hit1)      return FWD_EXMEM;
    else if (hit2) return FWD_MEMWB;
    else           return FWD_RF;
  endfunction

  always_comb begin
    w_entry         = SLOT_BUBBLE;
    w_entry.valid   = 1'b1;
    w_entry.dest    = SLOT_DEST_W'(i_id_dest);
    w_entry.is_load = i_id_is_load;
  end

  assign w_insert = i_id_valid && i_id_dest_we && !w_stall && !i_flush;

  dest_scoreboard_pipe #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_pipe (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_insert (w_insert),
    .i_entry  (w_entry),
    .o_slots  (w_slots)
  );

  // Slots past MEM and the padding bits of dest feed no comparator.
  assign w_unused_slot_bits = ^w_slots;

  assign w_hit_a1 = f_match(w_slots[0], i_id_src_a_used, i_id_src_a);
  assign w_hit_a2 = f_match(w_slots[1], i_id_src_a_used, i_id_src_a);
  assign w_hit_b1 = f_match(w_slots[0], i_id_src_b_used, i_id_src_b);
  assign w_hit_b2 = f_match(w_slots[1], i_id_src_b_used, i_id_src_b);

  always_comb begin
    if (FORWARD_EN != 0) begin
      w_hazard = (w_hit_a1 || w_hit_b1) && w_slots[0].is_load;
    end else begin
      w_hazard = w_hit_a1 || w_hit_b1 || w_hit_a2 || w_hit_b2;
    end
    // Flush overrides stall; reset masks it so nothing stale escapes.
    w_stall = !i_rst && i_id_valid && !i_flush && w_hazard;
  end

  always_comb begin
    w_fwd_a_nxt = FWD_RF;
    w_fwd_b_nxt = FWD_RF;
    if ((FORWARD_EN != 0) && !w_stall && !i_flush) begin
      w_fwd_a_nxt = f_sel(w_hit_a1, w_hit_a2);
      w_fwd_b_nxt = f_sel(w_hit_b1, w_hit_b2);
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_fwd_a     <= FWD_RF;
      r_fwd_b     <= FWD_RF;
      r_stall_cnt <= '0;
    end else begin
      r_fwd_a <= w_fwd_a_nxt;
      r_fwd_b <= w_fwd_b_nxt;
      if (w_stall && (r_stall_cnt != '1)) begin
        r_stall_cnt <= r_stall_cnt + 1'b1;
      end
    end
  end

  assign o_stall       = w_stall;
  assign o_fwd_sel_a   = r_fwd_a;
  assign o_fwd_sel_b   = r_fwd_b;
  assign o_stall_count = r_stall_cnt;

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid, a_used, b_used, we, is_load, flush;
  logic [3:0] src_a, src_b, dest;

  // u_f: forwarding, defaults.  u_s: stall-only.  u_z: r0 masked, 3-bit counter.
  logic        stall_f, stall_s, stall_z;
  logic [1:0]  fa_f, fb_f, fa_s, fb_s, fa_z, fb_z;
  logic [15:0] cnt_f, cnt_s;
  logic [2:0]  cnt_z;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  hazard_forward_unit #(
    .REG_ADDR_WIDTH(4), .NUM_SLOTS(3), .FORWARD_EN(1), .R0_ZERO(0), .STALL_CNT_WIDTH(16)
  ) u_f (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_src_a(src_a), .i_id_src_a_used(a_used),
    .i_id_src_b(src_b), .i_id_src_b_used(b_used),
    .i_id_dest(dest), .i_id_dest_we(we), .i_id_is_load(is_load), .i_flush(flush),
    .o_stall(stall_f), .o_fwd_sel_a(fa_f), .o_fwd_sel_b(fb_f), .o_stall_count(cnt_f)
  );

  hazard_forward_unit #(
    .REG_ADDR_WIDTH(4), .NUM_SLOTS(3), .FORWARD_EN(0), .R0_ZERO(0), .STALL_CNT_WIDTH(16)
  ) u_s (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_src_a(src_a), .i_id_src_a_used(a_used),
    .i_id_src_b(src_b), .i_id_src_b_used(b_used),
    .i_id_dest(dest), .i_id_dest_we(we), .i_id_is_load(is_load), .i_flush(flush),
    .o_stall(stall_s), .o_fwd_sel_a(fa_s), .o_fwd_sel_b(fb_s), .o_stall_count(cnt_s)
  );

  hazard_forward_unit #(
    .REG_ADDR_WIDTH(4), .NUM_SLOTS(3), .FORWARD_EN(1), .R0_ZERO(1), .STALL_CNT_WIDTH(3)
  ) u_z (
    .i_clk(clk), .i_rst(rst), .i_id_valid(id_valid),
    .i_id_src_a(src_a), .i_id_src_a_used(a_used),
    .i_id_src_b(src_b), .i_id_src_b_used(b_used),
    .i_id_dest(dest), .i_id_dest_we(we), .i_id_is_load(is_load), .i_flush(flush),
    .o_stall(stall_z), .o_fwd_sel_a(fa_z), .o_fwd_sel_b(fb_z), .o_stall_count(cnt_z)
  );

  // Inputs change 1 time unit after the rising edge; checks happen at the
  // falling edge (combinational stall) or 1 unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] a, input logic au,
                       input logic [3:0] b, input logic bu, input logic [3:0] d,
                       input logic w, input logic ld, input logic fl);
    id_valid = v; src_a = a; a_used = au; src_b = b; b_used = bu;
    dest = d; we = w; is_load = ld; flush = fl;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle();
    repeat (2) tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL reset_stall_f got=%b exp=0", stall_f); end
    total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL reset_stall_s got=%b exp=0", stall_s); end
    total++; if ({fa_f, fb_f} !== 4'b0000) begin bad++; $display("FAIL reset_fwd_f got=%b exp=0000", {fa_f, fb_f}); end
    total++; if (cnt_f !== 16'd0) begin bad++; $display("FAIL reset_cnt_f got=%0d exp=0", cnt_f); end
    total++; if (cnt_z !== 3'd0) begin bad++; $display("FAIL reset_cnt_z got=%0d exp=0", cnt_z); end
  endtask

  task automatic test_alu_forward();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd3, 1'b1, 1'b0, 1'b0); // ALU -> r3
    tick();
    drive(1'b1, 4'd3, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); // reads r3
    @(negedge clk);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL alu_fwd_stall got=%b exp=0", stall_f); end
    tick();
    idle();
    total++; if (fa_f !== 2'b01) begin bad++; $display("FAIL alu_fwd_sel_a got=%b exp=01", fa_f); end
    total++; if (fb_f !== 2'b00) begin bad++; $display("FAIL alu_fwd_sel_b got=%b exp=00", fb_f); end
    tick();
    total++; if (fa_f !== 2'b00) begin bad++; $display("FAIL alu_fwd_clear got=%b exp=00", fa_f); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0); // load r5
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); // reads r5 as b
    @(negedge clk);
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL load_use_stall got=%b exp=1", stall_f); end
    tick();
    @(negedge clk);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL load_use_one_bubble got=%b exp=0", stall_f); end
    total++; if (cnt_f !== 16'd1) begin bad++; $display("FAIL load_use_cnt got=%0d exp=1", cnt_f); end
    total++; if (fb_f !== 2'b00) begin bad++; $display("FAIL load_use_sel_in_stall got=%b exp=00", fb_f); end
    tick();
    idle();
    total++; if (fb_f !== 2'b10) begin bad++; $display("FAIL load_use_sel_b got=%b exp=10", fb_f); end
    total++; if (cnt_f !== 16'd1) begin bad++; $display("FAIL load_use_cnt_hold got=%0d exp=1", cnt_f); end
  endtask

  task automatic test_stall_only();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0); // ALU -> r2
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); // reads r2
    @(negedge clk);
    total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL nofwd_adj_stall1 got=%b exp=1", stall_s); end
    tick();
    @(negedge clk);
    total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL nofwd_adj_stall2 got=%b exp=1", stall_s); end
    tick();
    @(negedge clk);
    total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL nofwd_adj_release got=%b exp=0", stall_s); end
    total++; if (cnt_s !== 16'd2) begin bad++; $display("FAIL nofwd_adj_cnt got=%0d exp=2", cnt_s); end
    tick();
    idle();
    total++; if ({fa_s, fb_s} !== 4'b0000) begin bad++; $display("FAIL nofwd_sel got=%b exp=0000", {fa_s, fb_s}); end

    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd2, 1'b1, 1'b0, 1'b0); // ALU -> r2
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd9, 1'b1, 1'b0, 1'b0); // independent -> r9
    tick();
    drive(1'b1, 4'd2, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); // reads r2
    @(negedge clk);
    total++; if (stall_s !== 1'b1) begin bad++; $display("FAIL nofwd_gap_stall got=%b exp=1", stall_s); end
    tick();
    @(negedge clk);
    total++; if (stall_s !== 1'b0) begin bad++; $display("FAIL nofwd_gap_release got=%b exp=0", stall_s); end
    total++; if (cnt_s !== 16'd1) begin bad++; $display("FAIL nofwd_gap_cnt got=%0d exp=1", cnt_s); end
  endtask

  task automatic test_youngest_and_r0();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0); // r4 (older)
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd4, 1'b1, 1'b0, 1'b0); // r4 (younger)
    tick();
    drive(1'b1, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); // reads r4
    tick();
    total++; if (fa_f !== 2'b01) begin bad++; $display("FAIL youngest_wins got=%b exp=01", fa_f); end
    tick(); // same reader again: only slot2 holds r4 now
    idle();
    total++; if (fa_f !== 2'b10) begin bad++; $display("FAIL slot2_fwd got=%b exp=10", fa_f); end

    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b1, 1'b0); // load r0
    tick();
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); // reads r0, r0
    @(negedge clk);
    total++; if (stall_z !== 1'b0) begin bad++; $display("FAIL r0_zero_stall got=%b exp=0", stall_z); end
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL r0_live_stall got=%b exp=1", stall_f); end

    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b1, 1'b0, 1'b0); // ALU -> r0
    tick();
    drive(1'b1, 4'd0, 1'b1, 4'd0, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    tick();
    idle();
    total++; if ({fa_z, fb_z} !== 4'b0000) begin bad++; $display("FAIL r0_zero_fwd got=%b exp=0000", {fa_z, fb_z}); end
    total++; if ({fa_f, fb_f} !== 4'b0101) begin bad++; $display("FAIL r0_live_fwd got=%b exp=0101", {fa_f, fb_f}); end
  endtask

  task automatic test_flush();
    do_reset();
    drive(1'b1, 4'd0, 1'b0, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0); // load r5
    tick();
    drive(1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 4'd5, 1'b1, 1'b1, 1'b1); // load r5 <- r5, flushed
    @(negedge clk);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL flush_stall got=%b exp=0", stall_f); end
    tick();
    total++; if (cnt_f !== 16'd0) begin bad++; $display("FAIL flush_cnt got=%0d exp=0", cnt_f); end
    total++; if (fb_f !== 2'b00) begin bad++; $display("FAIL flush_sel got=%b exp=00", fb_f); end
    flush = 1'b0;
    @(negedge clk);
    // Slot1 must now be a bubble, so the original load sits in slot2 only.
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL flush_bubble got=%b exp=0", stall_f); end
    tick();
    idle();
    total++; if (fb_f !== 2'b10) begin bad++; $display("FAIL flush_after_sel got=%b exp=10", fb_f); end
  endtask

  task automatic test_saturate_and_reset();
    do_reset();
    // load r5 <- r5 held in ID: stalls every second cycle.
    drive(1'b1, 4'd5, 1'b1, 4'd0, 1'b0, 4'd5, 1'b1, 1'b1, 1'b0);
    repeat (6) tick();
    total++; if (cnt_z !== 3'd3) begin bad++; $display("FAIL sat_mid got=%0d exp=3", cnt_z); end
    repeat (14) tick();
    total++; if (cnt_z !== 3'd7) begin bad++; $display("FAIL sat_hold got=%0d exp=7", cnt_z); end
    total++; if (cnt_f !== 16'd10) begin bad++; $display("FAIL sat_wide got=%0d exp=10", cnt_f); end
    tick();
    total++; if (fa_f !== 2'b10) begin bad++; $display("FAIL pre_reset_sel got=%b exp=10", fa_f); end
    @(negedge clk);
    total++; if (stall_f !== 1'b1) begin bad++; $display("FAIL pre_reset_stall got=%b exp=1", stall_f); end
    rst = 1'b1;
    #1;
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL reset_masks_stall got=%b exp=0", stall_f); end
    tick();
    rst = 1'b0;
    @(negedge clk);
    total++; if (stall_f !== 1'b0) begin bad++; $display("FAIL post_reset_stall got=%b exp=0", stall_f); end
    total++; if ({fa_f, fb_f} !== 4'b0000) begin bad++; $display("FAIL post_reset_sel got=%b exp=0000", {fa_f, fb_f}); end
    total++; if (cnt_f !== 16'd0) begin bad++; $display("FAIL post_reset_cnt_f got=%0d exp=0", cnt_f); end
    total++; if (cnt_z !== 3'd0) begin bad++; $display("FAIL post_reset_cnt_z got=%0d exp=0", cnt_z); end
  endtask

  initial begin
    rst = 1'b1;
    idle();
    test_reset();
    test_alu_forward();
    test_load_use();
    test_stall_only();
    test_youngest_and_r0();
    test_flush();
    test_saturate_and_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hazard_forward_unit.md
Name: hazard_forward_unit

Overview:
- Parametrised successor to the current hazard detector in the 5-stage pipeline processor.
- Sits beside the ID stage. Tracks in-flight destination registers through EX, MEM and WB in an internal scoreboard pipe.
- Produces a stall for IF/ID plus registered EX-stage forwarding selects.
- Supports forwarding mode and stall-only mode, load-use detection, flush bubbles, and a saturating stall counter.

Parameters:
- REG_ADDR_WIDTH, 4: register address width.
- NUM_SLOTS, 3: tracked post-ID stages. Slot1 = EX, slot2 = MEM, slot3 = WB.
- FORWARD_EN, 1: 1 = forward and stall only on load-use; 0 = stall until the producer leaves MEM.
- R0_ZERO, 0: 1 = register 0 never matches a hazard.
- STALL_CNT_WIDTH, 16: width of stall_count.

Ports:
- Clock  in  1  pipeline clock
- Reset  in  1  synchronous, active-high reset
- id_valid  in  1  ID holds a real instruction
- id_src_a  in  REG_ADDR_WIDTH  first source register
- id_src_a_used  in  1  instruction reads src_a
- id_src_b  in  REG_ADDR_WIDTH  second source register
- id_src_b_used  in  1  instruction reads src_b
- id_dest  in  REG_ADDR_WIDTH  destination register
- id_dest_we  in  1  instruction writes id_dest
- id_is_load  in  1  result comes from data memory
- flush  in  1  jump taken; kill the ID instruction
- stall  out  1  hold PC and IF_ID; insert a bubble into EX
- fwd_sel_a  out  2  EX operand A source: 00 RF, 01 EX_MEM ALU result, 10 MEM_WB result
- fwd_sel_b  out  2  same encoding for operand B
- stall_count  out  STALL_CNT_WIDTH  cycles with stall asserted, saturating

Behaviour:
- Slot entry fields: valid, dest, is_load.
- Every non-reset edge:
  - slot[k+1] <= slot[k] for k = 1 to NUM_SLOTS-1; the oldest entry retires.
  - slot1 <= {1, id_dest, id_is_load} when id_valid & id_dest_we & !stall & !flush; otherwise slot1 <= bubble (valid = 0).
- match(s, k) = slot[k].valid & src s used & slot[k].dest == s & !(R0_ZERO & s == 0).
- Stall, FORWARD_EN = 1: stall = id_valid & !flush & (match(a,1) | match(b,1)) & slot1.is_load. Load-use costs exactly 1 bubble.
- Stall, FORWARD_EN = 0: stall = id_valid & !flush & any match against slot1 or slot2.
  - A producer 1 ahead costs 2 bubbles; 2 ahead costs 1 bubble.
- Stall is combinational from the slots and ID inputs, and is forced to 0 while Reset is high.
- Forwarding selects are registered. They are computed in the ID cycle and valid during that instruction's EX cycle.
  - match slot1 -> 01.
  - else match slot2 -> 10.
  - else 00.
  - Youngest producer wins.
  - When stall or flush is asserted, or FORWARD_EN = 0, the next-cycle selects are 00.
- RF requirement: the register file is write-through (same-cycle WB write visible to an ID read). Slot3 therefore never needs forwarding; it exists for stall-only timing checks and future depth.
- Flush and stall together: flush wins. stall = 0, a bubble is inserted, and the counter does not increment.
- stall_count increments each cycle stall = 1 and saturates at all-ones. No wrap.
- Reset values: all slots invalid, fwd_sel_a/b = 00, stall = 0, stall_count = 0.
- Reset mid-operation clears all in-flight state at the next edge; no hazard survives reset.
- Latency: stall takes effect in the same cycle; forwarding selects take effect 1 cycle later (EX).

Decomposition:
- Shared package hazard_pkg:
  - fwd select constants FWD_RF = 2'b00, FWD_EXMEM = 2'b01, FWD_MEMWB = 2'b10.
  - slot entry typedef (valid, dest, is_load).
- Sub-module dest_scoreboard_pipe: the NUM_SLOTS-deep shift register of entries, with its insert/bubble input and per-slot outputs.
- Top level holds the comparators, stall logic, forwarding registers and counter.

Test Plan:
- FORWARD_EN = 1, ALU op writing r3 followed immediately by a reader of r3 as src_a -> no stall; next cycle fwd_sel_a = 01.
- FORWARD_EN = 1, load r5 followed by a reader of r5 as src_b -> stall = 1 for exactly one cycle, stall_count = 1; after the bubble, fwd_sel_b = 10.
- FORWARD_EN = 0, r2 producer followed immediately by a reader -> stall for 2 cycles; with one independent instruction between them -> 1 cycle; fwd selects stay 00.
- Producers r4 in slot1 and r4 in slot2 both matching -> fwd_sel_a = 01 (youngest wins). With R0_ZERO = 1 and r0 sources -> never stall or forward.
- Load-use stall with flush asserted in the same cycle -> stall = 0, slot1 bubble, stall_count unchanged.
- Force stall_count near all-ones and hold a hazard -> counter saturates. Assert Reset mid-hazard -> next cycle stall = 0, selects 00, counter 0.
